// File: rtl/cpc_bus_cycle_decoder_if.sv
// Z80 bus strobes in, decoded cycle events out.
// Master drives the Z80 side; slave is the decoder.
interface cpc_bus_cycle_decoder_if;

    logic       mreq_b;
    logic       iorq_b;
    logic       rfsh_b;
    logic       wr_b;
    logic       adr15;
    logic       adr14;
    logic [7:0] data;

    logic [5:0] ramblock;
    logic       cfg_wr;
    logic       mem_start;
    logic       mem_wr;
    logic       mem_end;
    logic       rfsh_start;
    logic       io_end;
    logic [1:0] blk_hi;
    logic [2:0] tstate;
    logic       bus_err;

    modport master (
        output mreq_b,
        output iorq_b,
        output rfsh_b,
        output wr_b,
        output adr15,
        output adr14,
        output data,
        input  ramblock,
        input  cfg_wr,
        input  mem_start,
        input  mem_wr,
        input  mem_end,
        input  rfsh_start,
        input  io_end,
        input  blk_hi,
        input  tstate,
        input  bus_err
    );

    modport slave (
        input  mreq_b,
        input  iorq_b,
        input  rfsh_b,
        input  wr_b,
        input  adr15,
        input  adr14,
        input  data,
        output ramblock,
        output cfg_wr,
        output mem_start,
        output mem_wr,
        output mem_end,
        output rfsh_start,
        output io_end,
        output blk_hi,
        output tstate,
        output bus_err
    );

endinterface

// File: rtl/cpc_bus_cycle_decoder.sv
// Z80 bus cycle classifier and bank-select register
// for the 512K RAM expansion front end.
module cpc_bus_cycle_decoder #(
    parameter logic [1:0] CFG_PREFIX = 2'b11,
    parameter logic [2:0] TS_MAX     = 3'd7
) (
    input logic                     clk,
    input logic                     reset,
    cpc_bus_cycle_decoder_if.slave  bus
);

    typedef enum logic [2:0] {
        ARM,
        IDLE,
        MEM,
        RFSH,
        IO,
        HOLD
    } state_t;

    logic       mreq_s;
    logic       iorq_s;
    logic       rfsh_s;
    logic       wr_s;
    logic       adr15_s;
    logic       adr14_s;
    logic [7:0] data_s;

    state_t     state_q;
    state_t     state_n;

    logic [5:0] ramblock_q;
    logic [5:0] ramblock_n;
    logic       cfg_wr_q;
    logic       cfg_wr_n;
    logic       mem_start_q;
    logic       mem_start_n;
    logic       mem_wr_q;
    logic       mem_wr_n;
    logic       mem_end_q;
    logic       mem_end_n;
    logic       rfsh_start_q;
    logic       rfsh_start_n;
    logic       io_end_q;
    logic       io_end_n;
    logic [1:0] blk_hi_q;
    logic [1:0] blk_hi_n;
    logic [2:0] tstate_q;
    logic [2:0] tstate_n;
    logic       bus_err_q;
    logic       bus_err_n;
    logic       pend_q;
    logic       pend_n;
    logic [5:0] pdat_q;
    logic [5:0] pdat_n;

    logic [2:0] ts_inc;
    logic       cfg_hit;

    assign ts_inc  = (tstate_q >= TS_MAX) ? TS_MAX : tstate_q + 3'd1;
    assign cfg_hit = !wr_s && !adr15_s && (data_s[7:6] == CFG_PREFIX);

    // Input register; strobes reset to "asserted" so ARM needs a real idle sample
    always_ff @(posedge clk) begin
        if (reset) begin
            mreq_s  <= 1'b0;
            iorq_s  <= 1'b0;
            rfsh_s  <= 1'b0;
            wr_s    <= 1'b0;
            adr15_s <= 1'b0;
            adr14_s <= 1'b0;
            data_s  <= 8'h00;
        end else begin
            mreq_s  <= bus.mreq_b;
            iorq_s  <= bus.iorq_b;
            rfsh_s  <= bus.rfsh_b;
            wr_s    <= bus.wr_b;
            adr15_s <= bus.adr15;
            adr14_s <= bus.adr14;
            data_s  <= bus.data;
        end
    end

    // Next state, event pulses and register updates from the sampled bus
    always_comb begin
        state_n      = state_q;
        ramblock_n   = ramblock_q;
        cfg_wr_n     = 1'b0;
        mem_start_n  = 1'b0;
        mem_wr_n     = mem_wr_q;
        mem_end_n    = 1'b0;
        rfsh_start_n = 1'b0;
        io_end_n     = 1'b0;
        blk_hi_n     = blk_hi_q;
        tstate_n     = tstate_q;
        bus_err_n    = bus_err_q;
        pend_n       = pend_q;
        pdat_n       = pdat_q;

        unique case (state_q)
            ARM: begin
                if (mreq_s && iorq_s && wr_s) begin
                    state_n = IDLE;
                end
            end
            IDLE: begin
                if (!mreq_s && !iorq_s) begin
                    state_n   = HOLD;
                    bus_err_n = 1'b1;
                end else if (!mreq_s && !rfsh_s) begin
                    state_n      = RFSH;
                    rfsh_start_n = 1'b1;
                    tstate_n     = 3'd0;
                end else if (!mreq_s) begin
                    state_n     = MEM;
                    mem_start_n = 1'b1;
                    blk_hi_n    = {adr15_s, adr14_s};
                    mem_wr_n    = 1'b0;
                    tstate_n    = 3'd0;
                end else if (!iorq_s) begin
                    state_n  = IO;
                    tstate_n = 3'd0;
                    pend_n   = 1'b0;
                end
            end
            MEM: begin
                tstate_n = ts_inc;
                if (!wr_s) begin
                    mem_wr_n = 1'b1;
                end
                if (mreq_s) begin
                    mem_end_n = 1'b1;
                    state_n   = IDLE;
                end
            end
            RFSH: begin
                tstate_n = ts_inc;
                if (mreq_s) begin
                    state_n = IDLE;
                end
            end
            IO: begin
                tstate_n = ts_inc;
                if (iorq_s) begin
                    io_end_n = 1'b1;
                    if (pend_q) begin
                        ramblock_n = pdat_q;
                        cfg_wr_n   = 1'b1;
                        pend_n     = 1'b0;
                    end
                    state_n = IDLE;
                end else if (cfg_hit) begin
                    pend_n = 1'b1;
                    pdat_n = data_s[5:0];
                end
            end
            HOLD: begin
                if (mreq_s && iorq_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = ARM;
            end
        endcase
    end

    // State and registered outputs; reset abandons any cycle in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARM;
            ramblock_q   <= 6'd0;
            cfg_wr_q     <= 1'b0;
            mem_start_q  <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_end_q    <= 1'b0;
            rfsh_start_q <= 1'b0;
            io_end_q     <= 1'b0;
            blk_hi_q     <= 2'b00;
            tstate_q     <= 3'd0;
            bus_err_q    <= 1'b0;
            pend_q       <= 1'b0;
            pdat_q       <= 6'd0;
        end else begin
            state_q      <= state_n;
            ramblock_q   <= ramblock_n;
            cfg_wr_q     <= cfg_wr_n;
            mem_start_q  <= mem_start_n;
            mem_wr_q     <= mem_wr_n;
            mem_end_q    <= mem_end_n;
            rfsh_start_q <= rfsh_start_n;
            io_end_q     <= io_end_n;
            blk_hi_q     <= blk_hi_n;
            tstate_q     <= tstate_n;
            bus_err_q    <= bus_err_n;
            pend_q       <= pend_n;
            pdat_q       <= pdat_n;
        end
    end

    assign bus.ramblock   = ramblock_q;
    assign bus.cfg_wr     = cfg_wr_q;
    assign bus.mem_start  = mem_start_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_end    = mem_end_q;
    assign bus.rfsh_start = rfsh_start_q;
    assign bus.io_end     = io_end_q;
    assign bus.blk_hi     = blk_hi_q;
    assign bus.tstate     = tstate_q;
    assign bus.bus_err    = bus_err_q;

endmodule

// File: tb/tb_cpc_bus_cycle_decoder.sv
// Scoreboard bench for cpc_bus_cycle_decoder: directed Z80 cycles
// push expected events; a negedge monitor pops and compares.
module tb_cpc_bus_cycle_decoder;

    typedef struct packed {
        logic [4:0]  ev;
        logic [5:0]  rb;
        logic [1:0]  bh;
        logic        mw;
        logic [2:0]  ts;
        logic        be;
        logic [31:0] at;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    rec_t exp_q[$];

    logic [5:0] rb_m = 6'd0;
    logic [1:0] bh_m = 2'b00;
    logic       mw_m = 1'b0;
    logic [2:0] ts_m = 3'd0;
    logic       be_m = 1'b0;

    cpc_bus_cycle_decoder_if bus();

    cpc_bus_cycle_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] ev_now();
        return {bus.mem_start, bus.mem_end, bus.rfsh_start,
                bus.io_end, bus.cfg_wr};
    endfunction

    // Monitor: every event pulse must match the oldest expectation
    always @(negedge clk) begin
        rec_t got;
        rec_t e;
        if (!reset && (ev_now() != 5'b0)) begin
            got = {ev_now(), bus.ramblock, bus.blk_hi, bus.mem_wr,
                   bus.tstate, bus.bus_err, 32'(cyc)};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %h required none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL event: got %h required %h", got, e);
                end
            end
        end
    end

    function automatic logic [17:0] stat();
        return {ev_now(), bus.ramblock, bus.blk_hi, bus.mem_wr,
                bus.tstate, bus.bus_err};
    endfunction

    task automatic chk(input string nm, input logic [17:0] exp);
        logic [17:0] got;
        got = stat();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    function automatic logic [17:0] mstat();
        return {5'b0, rb_m, bh_m, mw_m, ts_m, be_m};
    endfunction

    task automatic push(input logic [4:0] ev, input logic [2:0] ts,
                        input int at);
        exp_q.push_back({ev, rb_m, bh_m, mw_m, ts, be_m, 32'(at)});
    endtask

    function automatic logic [2:0] sat(input int n);
        return (n > 7) ? 3'd7 : 3'(n);
    endfunction

    task automatic io_cycle(input logic a15, input logic wr,
                            input logic [7:0] d, input int n);
        int  n0;
        logic q;
        q = wr && !a15 && (d[7:6] == 2'b11) && (n >= 2);
        @(negedge clk);
        n0 = cyc;
        if (q) rb_m = d[5:0];
        ts_m = sat(n);
        push(q ? 5'b00011 : 5'b00010, ts_m, n0 + n + 2);
        bus.adr15  = a15;
        bus.adr14  = 1'b1;
        bus.data   = d;
        bus.iorq_b = 1'b0;
        bus.wr_b   = ~wr;
        repeat (n) @(negedge clk);
        bus.iorq_b = 1'b1;
        bus.wr_b   = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic mem_cycle(input logic [1:0] a, input int n,
                             input logic wr);
        int n0;
        @(negedge clk);
        n0 = cyc;
        bh_m = a;
        mw_m = 1'b0;
        push(5'b10000, 3'd0, n0 + 2);
        mw_m = wr;
        ts_m = sat(n);
        push(5'b01000, ts_m, n0 + n + 2);
        {bus.adr15, bus.adr14} = a;
        bus.mreq_b = 1'b0;
        @(negedge clk);
        if (wr) bus.wr_b = 1'b0;
        repeat (n - 1) @(negedge clk);
        bus.mreq_b = 1'b1;
        bus.wr_b   = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic rfsh_cycle(input int n);
        int n0;
        @(negedge clk);
        n0 = cyc;
        push(5'b00100, 3'd0, n0 + 2);
        ts_m = sat(n);
        {bus.adr15, bus.adr14} = 2'b10;
        bus.mreq_b = 1'b0;
        bus.rfsh_b = 1'b0;
        repeat (n) @(negedge clk);
        bus.mreq_b = 1'b1;
        bus.rfsh_b = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic b2b(input logic [1:0] a);
        int n0;
        @(negedge clk);
        n0 = cyc;
        bh_m = a;
        mw_m = 1'b0;
        push(5'b10000, 3'd0, n0 + 2);
        push(5'b01000, 3'd1, n0 + 3);
        push(5'b10000, 3'd0, n0 + 4);
        push(5'b01000, 3'd1, n0 + 5);
        ts_m = 3'd1;
        {bus.adr15, bus.adr14} = a;
        bus.mreq_b = 1'b0;
        @(negedge clk);
        bus.mreq_b = 1'b1;
        @(negedge clk);
        bus.mreq_b = 1'b0;
        @(negedge clk);
        bus.mreq_b = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic model_reset();
        rb_m = 6'd0;
        bh_m = 2'b00;
        mw_m = 1'b0;
        ts_m = 3'd0;
        be_m = 1'b0;
    endtask

    initial begin
        bus.mreq_b = 1'b1;
        bus.iorq_b = 1'b1;
        bus.rfsh_b = 1'b1;
        bus.wr_b   = 1'b1;
        bus.adr15  = 1'b0;
        bus.adr14  = 1'b0;
        bus.data   = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_state", 18'd0);
        repeat (2) @(negedge clk);

        io_cycle(1'b0, 1'b1, 8'hC5, 3);
        chk("ramblock_c5", mstat());
        io_cycle(1'b0, 1'b1, 8'h85, 3);
        io_cycle(1'b1, 1'b1, 8'hC5, 3);
        io_cycle(1'b0, 1'b0, 8'hC2, 3);
        chk("ramblock_kept", mstat());

        mem_cycle(2'b11, 3, 1'b1);
        mem_cycle(2'b10, 4, 1'b0);
        rfsh_cycle(2);
        chk("rfsh_levels", mstat());
        b2b(2'b01);
        io_cycle(1'b1, 1'b0, 8'h00, 9);
        chk("ts_saturate", mstat());

        @(negedge clk);
        bus.mreq_b = 1'b0;
        bus.iorq_b = 1'b0;
        repeat (2) @(negedge clk);
        be_m = 1'b1;
        chk("bus_err_set", mstat());
        bus.iorq_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("hold_no_start", mstat());
        bus.mreq_b = 1'b1;
        repeat (3) @(negedge clk);
        mem_cycle(2'b00, 2, 1'b0);
        chk("bus_err_sticky", mstat());

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk("reset_clears", mstat());
        repeat (2) @(negedge clk);

        bus.adr15  = 1'b0;
        bus.data   = 8'hFF;
        bus.iorq_b = 1'b0;
        bus.wr_b   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        bus.iorq_b = 1'b1;
        bus.wr_b   = 1'b1;
        repeat (4) @(negedge clk);
        model_reset();
        chk("reset_mid_io", mstat());
        io_cycle(1'b0, 1'b1, 8'hC3, 3);
        chk("after_reset_io", mstat());

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        while (exp_q.size() != 0) begin
            rec_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: got none required %h", e);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
